// File: rtl/ucie_protocol_tx_arbiter.sv
// Packet-aware round-robin arbiter merging protocol-layer flit streams into one
// registered output stage, with per-packet locking, idle timeout and orphan-flit dropping.
module ucie_protocol_tx_arbiter #(
    parameter int NUM_PROTOCOLS  = 4,
    parameter int FLIT_WIDTH     = 256,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_PROTOCOLS-1:0][FLIT_WIDTH-1:0] ul_flit,
    input  logic [NUM_PROTOCOLS-1:0]                 ul_valid,
    output logic [NUM_PROTOCOLS-1:0]                 ul_ready,
    input  logic [NUM_PROTOCOLS-1:0]                 ul_sop,
    input  logic [NUM_PROTOCOLS-1:0]                 ul_eop,
    input  logic [NUM_PROTOCOLS-1:0][7:0]            ul_vc,
    input  logic [NUM_PROTOCOLS-1:0]                 protocol_enable,
    output logic [FLIT_WIDTH-1:0]                    out_flit,
    output logic [7:0]                               out_vc,
    output logic                                     out_sop,
    output logic                                     out_eop,
    output logic [3:0]                               out_protocol_id,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     lock_active,
    output logic [3:0]                               locked_id,
    output logic                                     err_timeout,
    output logic                                     err_orphan
);

    localparam int IDW = $clog2(NUM_PROTOCOLS);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [IDW-1:0]           rr_ptr;
    logic [IDW-1:0]           locked_q;
    logic [IDW-1:0]           search_id;
    logic [IDW-1:0]           grant_id;
    logic                     search_found;
    logic                     grant_valid;
    logic                     stage_can_accept;
    logic                     accept;
    logic                     load;
    logic                     orphan;
    logic                     timeout_fire;
    logic                     rr_advance;
    logic [15:0]              idle_cnt;
    logic [NUM_PROTOCOLS-1:0] cand;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] x);
        return (x == IDW'(NUM_PROTOCOLS - 1)) ? '0 : x + IDW'(1);
    endfunction

    assign cand = protocol_enable & ul_valid;

    // Round-robin search: first candidate at or above rr_ptr, wrapping modulo NUM_PROTOCOLS.
    always_comb begin
        int idx;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        idx          = 0;
        search_found = 1'b0;
        search_id    = rr_ptr;
        for (int k = 0; k < NUM_PROTOCOLS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_PROTOCOLS) idx = idx - NUM_PROTOCOLS;
            if (!search_found && cand[IDW'(idx)]) begin
                search_found = 1'b1;
                search_id    = IDW'(idx);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept && ul_sop[grant_id] && !ul_eop[grant_id]) state_next = S_LOCKED;
            S_LOCKED: if ((accept && ul_eop[grant_id]) || timeout_fire)    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // FSM outputs: the grantee is pinned to the lock owner while a packet is in flight.
    always_comb begin
        lock_active      = (state == S_LOCKED);
        grant_id         = lock_active ? locked_q : search_id;
        grant_valid      = lock_active || search_found;
        stage_can_accept = !out_valid || out_ready;
        ul_ready         = '0;
        if (!rst && grant_valid && stage_can_accept) ul_ready[grant_id] = 1'b1;
        accept       = ul_ready[grant_id] && ul_valid[grant_id];
        load         = accept && (lock_active || ul_sop[grant_id]);
        orphan       = accept && !lock_active && !ul_sop[grant_id];
        timeout_fire = lock_active && !ul_valid[locked_q] &&
                       (idle_cnt == 16'(TIMEOUT_CYCLES - 1));
        rr_advance   = (accept && (orphan || ul_eop[grant_id])) || timeout_fire;
    end

    assign locked_id = 4'(locked_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr          <= '0;
            locked_q        <= '0;
            idle_cnt        <= '0;
            out_valid       <= 1'b0;
            out_flit        <= '0;
            out_vc          <= '0;
            out_sop         <= 1'b0;
            out_eop         <= 1'b0;
            out_protocol_id <= '0;
            err_timeout     <= 1'b0;
            err_orphan      <= 1'b0;
        end else begin
            err_timeout <= timeout_fire;
            err_orphan  <= orphan;

            if (rr_advance) rr_ptr <= next_idx(grant_id);
            if (!lock_active && state_next == S_LOCKED) locked_q <= grant_id;

            // Backpressure with data waiting holds the counter; only a silent owner ages the lock.
            if (!lock_active || accept || timeout_fire) idle_cnt <= '0;
            else if (!ul_valid[locked_q])               idle_cnt <= idle_cnt + 16'd1;

            if (load) begin
                out_valid       <= 1'b1;
                out_flit        <= ul_flit[grant_id];
                out_vc          <= ul_vc[grant_id];
                out_sop         <= ul_sop[grant_id];
                out_eop         <= ul_eop[grant_id];
                out_protocol_id <= 4'(grant_id);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
